// File: rtl/spinn_neu_if_pkg.sv
// Shared constants and types for the SpiNNaker neuron interface blocks.
// The AER source arbiter and its round-robin selector both import this package.
package spinn_neu_if;

    localparam int NUM_SRC_DEF = 3;
    localparam int TAG_W       = 2;
    localparam int DROP_W      = 16;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: grants the first requester found when
// scanning upward from the slot after the last grant, wrapping around.
module rr_arbiter
    import spinn_neu_if::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [TAG_W-1:0]   last,
    output logic [NUM_SRC-1:0] grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        // The last granted source is visited at the very end, so it only wins when alone.
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = (int'(last) + k) % NUM_SRC;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aer_src_arbiter.sv
// Merges several AER sources into one registered output stream with round-robin
// arbitration, optional source tagging and a saturating count of dropped beats.
module aer_src_arbiter
    import spinn_neu_if::*;
#(
    parameter int AER_WIDTH = 32,
    parameter int NUM_SRC   = NUM_SRC_DEF,
    parameter int TAG_POS   = 30
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SRC*AER_WIDTH-1:0]   src_data,
    input  logic [NUM_SRC-1:0]             src_vld,
    output logic [NUM_SRC-1:0]             src_rdy,
    input  logic [NUM_SRC-1:0]             src_en,
    input  logic                           tag_en,
    output logic [AER_WIDTH-1:0]           oaer_data,
    output logic                           oaer_vld,
    input  logic                           oaer_rdy,
    output logic [TAG_W-1:0]               grant_id,
    output logic [DROP_W-1:0]              drop_cnt
);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [NUM_SRC-1:0]   req;
    logic [NUM_SRC-1:0]   grant;
    logic [NUM_SRC-1:0]   drop;
    logic                 load;
    logic                 granted;
    logic [TAG_W-1:0]     grant_idx;
    logic [AER_WIDTH-1:0] sel_word;
    logic [2:0]           drop_num;
    logic [DROP_W:0]      drop_sum;
    logic [DROP_W-1:0]    drop_nxt;

    assign req      = src_vld & src_en;
    assign drop     = src_vld & ~src_en;
    assign load     = (state == ST_EMPTY) || oaer_rdy;
    assign granted  = load && !rst && (|grant);
    assign oaer_vld = (state == ST_FULL);

    // Disabled sources are always drained; enabled ones only see ready when granted.
    assign src_rdy  = rst ? '0 : (({NUM_SRC{load}} & grant) | ~src_en);

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr (
        .req   (req),
        .last  (grant_id),
        .grant (grant)
    );

    always_comb begin
        sel_word  = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant[i]) begin
                sel_word  = src_data[i*AER_WIDTH +: AER_WIDTH];
                grant_idx = TAG_W'(i);
            end
        end
        if (tag_en) begin
            sel_word[TAG_POS +: TAG_W] = grant_idx;
        end
    end

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            drop_num = drop_num + {2'b00, drop[i]};
        end
        drop_sum = {1'b0, drop_cnt} + (DROP_W+1)'(drop_num);
        drop_nxt = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
    end

    always_comb begin
        state_nxt = state;
        if (load) begin
            state_nxt = granted ? ST_FULL : ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Reset leaves grant_id on the last slot so source 0 wins the first arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            oaer_data <= '0;
            grant_id  <= TAG_W'(NUM_SRC-1);
            drop_cnt  <= '0;
        end else begin
            if (granted) begin
                oaer_data <= sel_word;
                grant_id  <= grant_idx;
            end
            drop_cnt <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_aer_src_arbiter.sv
// Directed self-checking bench for aer_src_arbiter with hand-computed expectations.
module tb_aer_src_arbiter;

    localparam int AW = 32;
    localparam int NS = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*AW-1:0]  src_data;
    logic [NS-1:0]     src_vld;
    logic [NS-1:0]     src_rdy;
    logic [NS-1:0]     src_en;
    logic              tag_en;
    logic [AW-1:0]     oaer_data;
    logic              oaer_vld;
    logic              oaer_rdy;
    logic [1:0]        grant_id;
    logic [15:0]       drop_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    aer_src_arbiter #(
        .AER_WIDTH (AW),
        .NUM_SRC   (NS),
        .TAG_POS   (30)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_data  (src_data),
        .src_vld   (src_vld),
        .src_rdy   (src_rdy),
        .src_en    (src_en),
        .tag_en    (tag_en),
        .oaer_data (oaer_data),
        .oaer_vld  (oaer_vld),
        .oaer_rdy  (oaer_rdy),
        .grant_id  (grant_id),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NS-1:0] vld, input logic [NS-1:0] en,
                                 input logic rdy, input logic tag);
        src_vld  = vld;
        src_en   = en;
        oaer_rdy = rdy;
        tag_en   = tag;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] word_of(input int src, input int k);
        return 32'h0000_0A00 + 32'(src * 16 + k * 256);
    endfunction

    task automatic set_words(input int k);
        for (int i = 0; i < NS; i++) begin
            src_data[i*AW +: AW] = word_of(i, k);
        end
    endtask

    initial begin
        rst      = 1'b1;
        src_data = '0;
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b0);
        tick();

        // reset state; src_rdy must stay low even for disabled sources
        checkOutput("rst_vld",   64'(oaer_vld),  64'd0);
        checkOutput("rst_data",  64'(oaer_data), 64'd0);
        checkOutput("rst_gid",   64'(grant_id),  64'd2);
        checkOutput("rst_drop",  64'(drop_cnt),  64'd0);
        checkOutput("rst_rdy",   64'(src_rdy),   64'd0);
        rst = 1'b0;
        tick();

        // all sources valid: grant order 0,1,2,0,1,2 with no bubbles
        for (int k = 0; k < 6; k++) begin
            set_words(k);
            applyStimulus(3'b111, 3'b111, 1'b1, 1'b0);
            if (k == 0) checkOutput("rr_first_vld", 64'(oaer_vld), 64'd0);
            checkOutput($sformatf("rr_rdy%0d", k), 64'(src_rdy), 64'(3'b001 << (k % 3)));
            tick();
            checkOutput($sformatf("rr_vld%0d", k),  64'(oaer_vld),  64'd1);
            checkOutput($sformatf("rr_data%0d", k), 64'(oaer_data), 64'(word_of(k % 3, k)));
            checkOutput($sformatf("rr_gid%0d", k),  64'(grant_id),  64'(k % 3));
        end
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        tick();
        checkOutput("rr_drain_vld", 64'(oaer_vld), 64'd0);
        checkOutput("rr_hold_gid",  64'(grant_id), 64'd2);

        // backpressure: only source 1 valid, downstream stalls for 5 cycles
        set_words(7);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        checkOutput("bp_load_rdy", 64'(src_rdy), 64'(3'b010));
        tick();
        set_words(8);
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp_rdy%0d", c),  64'(src_rdy),   64'd0);
            checkOutput($sformatf("bp_data%0d", c), 64'(oaer_data), 64'(word_of(1, 7)));
            checkOutput($sformatf("bp_vld%0d", c),  64'(oaer_vld),  64'd1);
            tick();
        end
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        tick();
        checkOutput("bp_once_vld", 64'(oaer_vld), 64'd0);
        checkOutput("bp_gid",      64'(grant_id), 64'd1);

        // tagging on source 2, then pass-through
        src_data[2*AW +: AW] = 32'h0000_1234;
        applyStimulus(3'b100, 3'b111, 1'b1, 1'b1);
        tick();
        checkOutput("tag_on",  64'(oaer_data), 64'h8000_1234);
        checkOutput("tag_gid", 64'(grant_id),  64'd2);
        applyStimulus(3'b100, 3'b111, 1'b1, 1'b0);
        tick();
        checkOutput("tag_off",     64'(oaer_data), 64'h0000_1234);
        checkOutput("tag_off_vld", 64'(oaer_vld),  64'd1);
        applyStimulus(3'b000, 3'b111, 1'b1, 1'b0);
        tick();

        // disabled source 1 drained and counted for 10 cycles
        for (int c = 0; c < 10; c++) begin
            applyStimulus(3'b010, 3'b101, 1'b1, 1'b0);
            checkOutput($sformatf("drn_rdy%0d", c), 64'(src_rdy), 64'(3'b010));
            tick();
            checkOutput($sformatf("drn_vld%0d", c), 64'(oaer_vld), 64'd0);
        end
        applyStimulus(3'b000, 3'b101, 1'b1, 1'b0);
        checkOutput("drn_cnt", 64'(drop_cnt), 64'd10);

        // saturation: 10 + 21841*3 + 1 = 65534, then 3 more
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        checkOutput("sat_rdy", 64'(src_rdy), 64'(3'b111));
        for (int c = 0; c < 21841; c++) tick();
        applyStimulus(3'b001, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("sat_fffe", 64'(drop_cnt), 64'hFFFE);
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        tick();
        checkOutput("sat_ffff", 64'(drop_cnt), 64'hFFFF);
        tick();
        checkOutput("sat_hold", 64'(drop_cnt), 64'hFFFF);

        // reset while FULL drops the held word and restores priority to source 0
        set_words(9);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        tick();
        checkOutput("rf_vld", 64'(oaer_vld), 64'd1);
        checkOutput("rf_gid", 64'(grant_id), 64'd1);
        rst = 1'b1;
        applyStimulus(3'b111, 3'b000, 1'b1, 1'b0);
        checkOutput("rf_rst_rdy", 64'(src_rdy),  64'd0);
        checkOutput("rf_rst_vld", 64'(oaer_vld), 64'd0);
        tick();
        rst = 1'b0;
        applyStimulus(3'b111, 3'b111, 1'b1, 1'b0);
        checkOutput("rf_gid2", 64'(grant_id), 64'd2);
        checkOutput("rf_drop", 64'(drop_cnt), 64'd0);
        checkOutput("rf_rdy",  64'(src_rdy),  64'(3'b001));
        tick();
        checkOutput("rf_first_gid",  64'(grant_id),  64'd0);
        checkOutput("rf_first_data", 64'(oaer_data), 64'(word_of(0, 9)));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/aer_src_arbiter.md
AER_SRC_ARBITER -- requirements
Module: aer_src_arbiter

Interface
REQ-001 Parameter AER_WIDTH, default 32: width of every AER word.
REQ-002 Parameter NUM_SRC, default 3, legal 2..4: number of AER sources.
REQ-003 Parameter TAG_POS, default 30, legal 0..AER_WIDTH-2: LSB of the 2-bit source tag field.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  reset; asynchronous, active-high.
REQ-006 src_data  in  NUM_SRC*AER_WIDTH  source words; source i occupies slice i.
REQ-007 src_vld  in  NUM_SRC  per-source valid.
REQ-008 src_rdy  out  NUM_SRC  per-source ready.
REQ-009 src_en  in  NUM_SRC  per-source enable; 0 means drain and discard that source.
REQ-010 tag_en  in  1  1 means overwrite data[TAG_POS+1:TAG_POS] with the source index.
REQ-011 oaer_data  out  AER_WIDTH  word to the downstream mapper.
REQ-012 oaer_vld  out  1  output valid.
REQ-013 oaer_rdy  in  1  downstream ready.
REQ-014 grant_id  out  2  index of the last source granted.
REQ-015 drop_cnt  out  16  count of discarded beats; saturates.

Function
REQ-016 A transfer on any valid/ready pair occurs in every cycle where both are 1.
REQ-017 The block has one output register and a two-state FSM: EMPTY (oaer_vld=0) and FULL (oaer_vld=1).
REQ-018 load = EMPTY | (FULL & oaer_rdy); this is the only condition under which a new word is accepted.
REQ-019 Requesters = src_vld & src_en; on load, exactly one requester is granted, round-robin, starting at index (grant_id+1) mod NUM_SRC.
REQ-020 src_rdy[i] for an enabled source = load & grant[i] (combinational); at most one enabled source sees ready in a cycle.
REQ-021 src_rdy[i] for a disabled source = 1 in every cycle after reset; each beat with src_vld[i]=1 is discarded.
REQ-022 drop_cnt increments by the number of discarded beats in that cycle (0..NUM_SRC) and saturates at 16'hFFFF.
REQ-023 A granted word appears on oaer_data with oaer_vld=1 on the cycle after the transfer (latency 1).
REQ-024 tag_en=1 replaces bits [TAG_POS+1:TAG_POS] with the 2-bit source index; tag_en=0 passes the word unchanged.
REQ-025 tag_en is sampled on the grant cycle.
REQ-026 grant_id updates only on a grant; it holds when no transfer occurs.
REQ-027 EMPTY -> FULL on a grant.
REQ-028 FULL -> EMPTY on oaer_rdy=1 with no requester.
REQ-029 FULL -> FULL on oaer_rdy=1 with a requester; the register reloads and there is no bubble (one word per cycle).
REQ-030 FULL with oaer_rdy=0: oaer_data and oaer_vld hold stable, and all enabled src_rdy are 0.
REQ-031 If src_en drops while a word is held, the held word is still delivered; only future beats are dropped.
REQ-032 No output bit depends combinationally on oaer_rdy except through src_rdy (REQ-020).

Reset
REQ-033 On rst: FSM=EMPTY, oaer_vld=0, oaer_data=0, grant_id=NUM_SRC-1 (so source 0 has first priority), drop_cnt=0.
REQ-034 On rst assertion mid-transfer, the held word is discarded without handshake; src_rdy is 0 for all sources while rst=1.

Structure
REQ-035 NUM_SRC default, the tag width (2) and the drop_cnt width (16) are defined as constants in the shared spinn_neu_if package.
REQ-036 Round-robin priority selection is one sub-module, rr_arbiter (inputs req and last grant; output one-hot grant), purely combinational.
REQ-037 The FSM, output register and counter reside in aer_src_arbiter.

Verification
REQ-038 Reset, then all 3 sources valid and enabled, oaer_rdy=1 -> grant order 0,1,2,0,1,2, one word per cycle, first oaer_vld on the cycle after the first transfer.
REQ-039 Only source 1 valid, oaer_rdy held 0 for 5 cycles -> oaer_data is stable, src_rdy=3'b000, no loss; release -> the word is delivered exactly once.
REQ-040 tag_en=1, source 2 word 32'h0000_1234, TAG_POS=30 -> oaer_data=32'h8000_1234; tag_en=0 -> 32'h0000_1234.
REQ-041 src_en=3'b101, source 1 valid for 10 cycles -> src_rdy[1]=1 throughout, drop_cnt=10, and no source-1 word appears on the output.
REQ-042 drop_cnt preloaded to 16'hFFFE by driving 65534 drops, then 3 more drops -> drop_cnt=16'hFFFF.
REQ-043 rst pulsed while FULL -> next cycle oaer_vld=0, grant_id=2, and source 0 is granted first afterwards.
